// File: rtl/simd_regfile_sb.sv
// Per-thread register file with scalar/SIMD access on two read ports and one write port,
// same-cycle write bypass, a per-entry pending scoreboard and a sequenced soft-clear sweep.
module simd_regfile_sb #(
  parameter int DW    = 28,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int LANES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       rs0,
  input  logic [AW-1:0]       rs1,
  input  logic                rd_simd0,
  input  logic                rd_simd1,
  output logic [LANES*DW-1:0] dout0,
  output logic [LANES*DW-1:0] dout1,
  output logic                busy0,
  output logic                busy1,
  input  logic                wen,
  input  logic                wr_simd,
  input  logic [AW-1:0]       dest_sel,
  input  logic [LANES*DW-1:0] data_in,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                sb_simd,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                wr_drop
);

  localparam int VW = LANES * DW;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DW-1:0]     rf_q [DEPTH];
  logic [DW-1:0]     rf_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic [DEPTH-1:0]  wmask;
  logic [DEPTH-1:0]  smask;
  logic [DW-1:0]     wdata [DEPTH];
  logic [AW-1:0]     ra0, ra1, wa, sa;
  logic              sweep;

  // Lane k of a base address wraps modulo DEPTH through the natural AW-bit overflow.
  function automatic logic [AW-1:0] lane_addr(input logic [AW-1:0] base, input int k);
    return base + AW'(k);
  endfunction

  function automatic logic [DW-1:0] lane_of(input logic [VW-1:0] v, input int k);
    return v[(LANES-1-k)*DW +: DW];
  endfunction

  assign sweep    = (state_q == SWEEP);
  assign clr_busy = sweep;
  assign wr_drop  = wr_drop_q;

  // Per-entry write and scoreboard-set decode; both are suppressed while sweeping.
  always_comb begin
    wmask = '0;
    smask = '0;
    wa    = '0;
    sa    = '0;
    for (int e = 0; e < DEPTH; e++) wdata[e] = '0;
    for (int k = 0; k < LANES; k++) begin
      wa = lane_addr(dest_sel, k);
      sa = lane_addr(sb_addr, k);
      if (wen && !sweep && (wr_simd || k == 0)) begin
        wmask[wa] = 1'b1;
        wdata[wa] = lane_of(data_in, k);
      end
      if (sb_set && !sweep && (sb_simd || k == 0)) smask[sa] = 1'b1;
    end
  end

  // Combinational read ports with bypass; an entry being written reads as not busy.
  always_comb begin
    dout0 = '0;
    dout1 = '0;
    busy0 = 1'b0;
    busy1 = 1'b0;
    ra0   = '0;
    ra1   = '0;
    for (int k = 0; k < LANES; k++) begin
      ra0 = lane_addr(rs0, k);
      ra1 = lane_addr(rs1, k);
      if (rd_simd0 || k == 0) begin
        dout0[(LANES-1-k)*DW +: DW] = wmask[ra0] ? wdata[ra0] : rf_q[ra0];
        busy0 = busy0 | (busy_q[ra0] & ~wmask[ra0]);
      end
      if (rd_simd1 || k == 0) begin
        dout1[(LANES-1-k)*DW +: DW] = wmask[ra1] ? wdata[ra1] : rf_q[ra1];
        busy1 = busy1 | (busy_q[ra1] & ~wmask[ra1]);
      end
    end
  end

  // Next state: set beats clear on the same entry, the sweep overrides both.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    busy_d    = (busy_q & ~wmask) | smask;
    for (int e = 0; e < DEPTH; e++) rf_d[e] = wmask[e] ? wdata[e] : rf_q[e];
    case (state_q)
      IDLE: begin
        if (clr_req) state_d = SWEEP;
      end
      SWEEP: begin
        wr_drop_d     = wen;
        rf_d[cnt_q]   = '0;
        busy_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
      busy_q    <= '0;
      for (int e = 0; e < DEPTH; e++) rf_q[e] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
      busy_q    <= busy_d;
      for (int e = 0; e < DEPTH; e++) rf_q[e] <= rf_d[e];
    end
  end

endmodule

// File: tb/tb_simd_regfile_sb.sv
// Directed scoreboard bench for simd_regfile_sb: expected values are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_simd_regfile_sb;
  localparam int DW    = 28;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LANES = 2;
  localparam int VW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs0, rs1, dest_sel, sb_addr;
  logic          rd_simd0, rd_simd1, wen, wr_simd, sb_set, sb_simd, clr_req;
  logic [VW-1:0] data_in, dout0, dout1;
  logic          busy0, busy1, clr_busy, wr_drop;

  logic [VW-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int n_sweep  = 0;

  simd_regfile_sb #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .rs0(rs0), .rs1(rs1), .rd_simd0(rd_simd0), .rd_simd1(rd_simd1),
    .dout0(dout0), .dout1(dout1), .busy0(busy0), .busy1(busy1), .wen(wen), .wr_simd(wr_simd),
    .dest_sel(dest_sel), .data_in(data_in), .sb_set(sb_set), .sb_addr(sb_addr),
    .sb_simd(sb_simd), .clr_req(clr_req), .clr_busy(clr_busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pk(input logic [DW-1:0] l0, input logic [DW-1:0] l1);
    return {l0, l1};
  endfunction

  task automatic expect_v(input logic [VW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs);
    logic [VW-1:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic s, input logic [VW-1:0] d);
    @(negedge clk);
    wen = 1'b1; wr_simd = s; dest_sel = a; data_in = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rs0 = '0; rs1 = '0; rd_simd0 = 1'b0; rd_simd1 = 1'b0;
    wen = 1'b0; wr_simd = 1'b0; dest_sel = '0; data_in = '0;
    sb_set = 1'b0; sb_addr = '0; sb_simd = 1'b0; clr_req = 1'b0;
    #2;
    expect_v('0); chk("rst_dout0", dout0);
    expect_v('0); chk("rst_dout1", dout1);
    expect_v('0); chk("rst_busy0", VW'(busy0));
    expect_v('0); chk("rst_clr_busy", VW'(clr_busy));
    expect_v('0); chk("rst_wr_drop", VW'(wr_drop));
    @(negedge clk);
    rst = 1'b0;

    // SIMD write then SIMD/scalar read
    do_write(4'd3, 1'b1, pk(28'hA, 28'hB));
    rs0 = 4'd3; rd_simd0 = 1'b1;
    expect_v(pk(28'hA, 28'hB)); #1; chk("t1_simd_read", dout0);
    rd_simd0 = 1'b0;
    expect_v(pk(28'hA, 28'h0)); #1; chk("t1_scalar_read", dout0);

    // wrap from entry 15 to entry 0
    do_write(4'd15, 1'b1, pk(28'hC, 28'hD));
    rs1 = 4'd15; rd_simd1 = 1'b1;
    expect_v(pk(28'hC, 28'hD)); #1; chk("t2_wrap_simd", dout1);
    rs0 = 4'd0; rd_simd0 = 1'b0;
    expect_v(pk(28'hD, 28'h0)); #1; chk("t2_wrap_entry0", dout0);

    // same-cycle bypass, mixed with an old-value lane
    @(negedge clk);
    wen = 1'b1; wr_simd = 1'b0; dest_sel = 4'd5; data_in = pk(28'h123, 28'h77);
    rs0 = 4'd5; rd_simd0 = 1'b0; rs1 = 4'd4; rd_simd1 = 1'b1;
    expect_v(pk(28'h123, 28'h0)); expect_v(pk(28'hB, 28'h123));
    #1; chk("t3_bypass_scalar", dout0); chk("t3_bypass_lane1", dout1);
    @(negedge clk);
    wen = 1'b0;
    expect_v(pk(28'h123, 28'h0)); #1; chk("t3_commit", dout0);

    // scoreboard set, partial clear, set-wins
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 4'd7; sb_simd = 1'b1; rs0 = 4'd7; rd_simd0 = 1'b0;
    expect_v('0); #1; chk("t4_busy_before_edge", VW'(busy0));
    @(negedge clk);
    sb_set = 1'b0;
    expect_v(VW'(1)); #1; chk("t4_busy7", VW'(busy0));
    rs0 = 4'd8;
    expect_v(VW'(1)); #1; chk("t4_busy8", VW'(busy0));
    rs0 = 4'd6;
    expect_v('0); #1; chk("t4_busy6_scalar", VW'(busy0));
    rd_simd0 = 1'b1;
    expect_v(VW'(1)); #1; chk("t4_busy6_simd", VW'(busy0));
    rd_simd0 = 1'b0;
    @(negedge clk);
    wen = 1'b1; wr_simd = 1'b0; dest_sel = 4'd8; data_in = pk(28'h88, 28'h0); rs0 = 4'd8;
    expect_v('0); #1; chk("t4_busy_bypass_mask", VW'(busy0));
    @(negedge clk);
    wen = 1'b0;
    expect_v('0); #1; chk("t4_busy8_cleared", VW'(busy0));
    rs0 = 4'd7;
    expect_v(VW'(1)); #1; chk("t4_busy7_kept", VW'(busy0));
    @(negedge clk);
    wen = 1'b1; wr_simd = 1'b0; dest_sel = 4'd7; data_in = pk(28'h71, 28'h0);
    sb_set = 1'b1; sb_addr = 4'd7; sb_simd = 1'b0;
    @(negedge clk);
    wen = 1'b0; sb_set = 1'b0; rs0 = 4'd7;
    expect_v(VW'(1)); #1; chk("t4_set_wins", VW'(busy0));
    do_write(4'd7, 1'b0, pk(28'h72, 28'h0));
    rs0 = 4'd7;
    expect_v('0); #1; chk("t4_busy7_write_clears", VW'(busy0));

    // fill, then sweep with a dropped write and an ignored sb_set / clr_req
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 1'b0, pk(DW'(32'h100 + i), 28'h0));
    rs0 = 4'd9; rd_simd0 = 1'b1;
    expect_v(pk(28'h109, 28'h10A)); #1; chk("t5_fill_read", dout0);
    rd_simd0 = 1'b0;
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 4'd2; sb_simd = 1'b1;
    @(negedge clk);
    sb_set = 1'b0; rs0 = 4'd2; clr_req = 1'b1;
    expect_v(VW'(1)); expect_v('0);
    #1; chk("t5_busy_pre", VW'(busy0)); chk("t5_idle_on_req", VW'(clr_busy));
    @(negedge clk);
    clr_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      wen = (c == 3); wr_simd = 1'b0; dest_sel = 4'd1; data_in = pk(28'hDEAD, 28'h0);
      sb_set = (c == 3); sb_addr = 4'd1; sb_simd = 1'b0; clr_req = (c == 5);
      rs0 = 4'd1; rd_simd0 = 1'b0; rs1 = 4'd15; rd_simd1 = 1'b0;
      #1;
      if (c == 3) begin
        expect_v('0); chk("t5_no_bypass", dout0);
        expect_v(pk(28'h10F, 28'h0)); chk("t5_sweep_old_value", dout1);
      end
      if (c == 4) begin expect_v(VW'(1)); chk("t5_wr_drop", VW'(wr_drop)); end
      if (c == 5) begin expect_v('0); chk("t5_wr_drop_pulse", VW'(wr_drop)); end
      if (!clr_busy) break;
      n_sweep++;
      @(negedge clk);
    end
    wen = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
    expect_v(VW'(16)); chk("t5_sweep_len", VW'(n_sweep));
    for (int i = 0; i < DEPTH; i++) begin
      rs0 = AW'(i); rd_simd0 = 1'b0;
      expect_v('0); expect_v('0);
      #1; chk("t5_clear_data", dout0); chk("t5_clear_busy", VW'(busy0));
    end

    // asynchronous reset in the middle of a sweep
    do_write(4'd12, 1'b0, pk(28'h777, 28'h0));
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 4'd13; sb_simd = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    sb_set = 1'b0; clr_req = 1'b0;
    repeat (6) @(negedge clk);
    rs0 = 4'd12; rd_simd0 = 1'b0; rs1 = 4'd12; rd_simd1 = 1'b1;
    expect_v(VW'(1)); expect_v(pk(28'h777, 28'h0)); expect_v(VW'(1));
    #1; chk("t6_mid_sweep", VW'(clr_busy)); chk("t6_pre_rst_data", dout0);
    chk("t6_pre_rst_busy", VW'(busy1));
    #1; rst = 1'b1;
    #1;
    expect_v('0); chk("t6_rst_clr_busy", VW'(clr_busy));
    expect_v('0); chk("t6_rst_dout0", dout0);
    expect_v('0); chk("t6_rst_dout1", dout1);
    expect_v('0); chk("t6_rst_busy1", VW'(busy1));
    expect_v('0); chk("t6_rst_wr_drop", VW'(wr_drop));
    @(negedge clk);
    rst = 1'b0;
    do_write(4'd12, 1'b0, pk(28'h555, 28'h0));
    rs0 = 4'd12; rd_simd0 = 1'b0;
    expect_v(pk(28'h555, 28'h0)); expect_v('0);
    #1; chk("t6_post_rst_write", dout0); chk("t6_post_rst_idle", VW'(clr_busy));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
